// File: rtl/seq_divider_if.sv
// Handshake and data bundle for seq_divider.
// The div_by_zero signal exists only when SEQ_DIVIDER_ZERO_DETECT_EN is defined.
interface seq_divider_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// 8-bit by 4-bit restoring sequential divider, one quotient bit per RUN cycle.
// Optional feature: SEQ_DIVIDER_ZERO_DETECT_EN adds div_by_zero and finishes a
// zero-divisor request after a single idle cycle instead of iterating.
module seq_divider (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  dvd_q, dvd_d;   // dividend shifts out MSB first, quotient bits shift in
  logic [3:0]  dvs_q, dvs_d;
  logic [4:0]  pr_q, pr_d;     // partial remainder
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  quo_q, quo_d;
  logic [3:0]  rem_q, rem_d;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
  logic        dbz_q, dbz_d;
  logic        pend_q, pend_d; // zero-divisor request waiting its one idle cycle
`endif

  logic [4:0]  shifted;
  logic        ge;
  logic [4:0]  step_pr;
  logic        accept;

  // One restoring step on the current partial remainder.
  always_comb begin
    shifted = {pr_q[3:0], dvd_q[7]};
    ge      = (shifted >= {1'b0, dvs_q});
    step_pr = ge ? (shifted - {1'b0, dvs_q}) : shifted;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    accept  = 1'b0;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    dbz_d   = dbz_q;
    pend_d  = pend_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
        if (pend_q) begin
          state_d = StDone;
          quo_d   = 8'hFF;
          rem_d   = 4'h0;
          dbz_d   = 1'b1;
          pend_d  = 1'b0;
        end else begin
          accept = bus.start;
        end
`else
        accept = bus.start;
`endif
      end
      StRun: begin
        pr_d  = step_pr;
        dvd_d = {dvd_q[6:0], ge};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = StDone;
          // A zero divisor naturally yields all-ones; remainder is forced clean.
          quo_d   = {dvd_q[6:0], ge};
          rem_d   = (dvs_q == 4'h0) ? 4'h0 : step_pr[3:0];
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      StDone: begin
        accept  = bus.start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      dvd_d   = bus.dividend;
      dvs_d   = bus.divisor;
      pr_d    = 5'd0;
      cnt_d   = 3'd7;
      state_d = StRun;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
      if (bus.divisor == 4'h0) begin
        state_d = StIdle;
        pend_d  = 1'b1;
      end
`endif
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      pr_q    <= 5'd0;
      cnt_q   <= 3'd0;
      quo_q   <= 8'd0;
      rem_q   <= 4'd0;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
      pend_q  <= pend_d;
`endif
    end
  end

  // Outputs decoded from state and result registers.
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
  assign bus.div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (both SEQ_DIVIDER_ZERO_DETECT_EN builds).
module tb_seq_divider;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seq_divider_if bus ();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start at the next edge k, scramble operands afterwards, and wait
  // for done. lat counts cycles from the k..k+1 interval; bcnt counts busy cycles.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (bus.busy === 1'b1) bcnt++;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d, want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run_op(8'd200, 4'd7, lat, bcnt);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++;
    if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bcnt); end
    checks++;
    if (bus.quotient !== 8'd28 || bus.remainder !== 4'd4) begin
      errors++;
      $display("FAIL basic_200_7: got q=%0d r=%0d want q=28 r=4", bus.quotient, bus.remainder);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.quotient !== 8'd28 || bus.remainder !== 4'd4) begin
      errors++;
      $display("FAIL basic_hold_idle: got q=%0d r=%0d want q=28 r=4", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'd255, 8'd5, 8'd0,  8'd9};
    logic [3:0] vb [4] = '{4'd1,   4'd9, 4'd15, 4'd2};
    logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd0,  8'd4};
    logic [3:0] er [4] = '{4'd0,   4'd5, 4'd0,  4'd1};
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, bcnt);
      checks++;
      if (lat !== 8 || bus.quotient !== eq[i] || bus.remainder !== er[i]) begin
        errors++;
        $display("FAIL vector_%0d_%0d: got lat=%0d q=%0d r=%0d want lat=8 q=%0d r=%0d",
                 va[i], vb[i], lat, bus.quotient, bus.remainder, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, dones, first;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0; first = -1;
    for (lat = 0; lat < 16; lat++) begin
      if (lat == 3) begin bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd2; end
      if (lat == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) begin
          first = lat;
          checks++;
          if (bus.quotient !== 8'd28 || bus.remainder !== 4'd4) begin
            errors++;
            $display("FAIL ignore_result: got q=%0d r=%0d want q=28 r=4",
                     bus.quotient, bus.remainder);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1 || first !== 8) begin
      errors++;
      $display("FAIL ignore_done_count: got dones=%0d at %0d want 1 at 8", dones, first);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, held;
    run_op(8'd200, 4'd7, lat, bcnt);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_enter_run: got busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    lat = 0; held = 1;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (bus.quotient !== 8'd28 || bus.remainder !== 4'd4) held = 0;
      lat++;
      @(negedge clk);
    end
    checks++;
    if (held !== 1) begin errors++; $display("FAIL b2b_hold: got held=%0d want 1", held); end
    checks++;
    if (lat !== 8 || bus.quotient !== 8'd33 || bus.remainder !== 4'd1) begin
      errors++;
      $display("FAIL b2b_100_3: got lat=%0d q=%0d r=%0d want lat=8 q=33 r=1",
               lat, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt, saw_done;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder} !== 14'd0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b q=%0d r=%0d want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (bus.done === 1'b1) saw_done = 1; end
    rst = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.done === 1'b1) saw_done = 1; end
    checks++;
    if (saw_done !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d want 0", saw_done); end
    run_op(8'd9, 4'd2, lat, bcnt);
    checks++;
    if (lat !== 8 || bus.quotient !== 8'd4 || bus.remainder !== 4'd1) begin
      errors++;
      $display("FAIL midrun_9_2: got lat=%0d q=%0d r=%0d want lat=8 q=4 r=1",
               lat, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    run_op(8'd77, 4'd0, lat, bcnt);
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    checks++;
    if (lat !== 1 || bcnt !== 0) begin
      errors++;
      $display("FAIL dz_latency: got lat=%0d busy=%0d want lat=1 busy=0", lat, bcnt);
    end
    checks++;
    if (bus.quotient !== 8'hFF || bus.remainder !== 4'h0 || bus.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: got q=%0h r=%0h dbz=%b want q=ff r=0 dbz=1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_hold: got %b want 1", bus.div_by_zero);
    end
    run_op(8'd9, 4'd2, lat, bcnt);
    checks++;
    if (bus.div_by_zero !== 1'b0 || bus.quotient !== 8'd4 || bus.remainder !== 4'd1) begin
      errors++;
      $display("FAIL dz_clear: got dbz=%b q=%0d r=%0d want dbz=0 q=4 r=1",
               bus.div_by_zero, bus.quotient, bus.remainder);
    end
`else
    checks++;
    if (lat !== 8 || bcnt !== 8) begin
      errors++;
      $display("FAIL dz_latency: got lat=%0d busy=%0d want lat=8 busy=8", lat, bcnt);
    end
    checks++;
    if (bus.quotient !== 8'hFF || bus.remainder !== 4'h0) begin
      errors++;
      $display("FAIL dz_result: got q=%0h r=%0h want q=ff r=0", bus.quotient, bus.remainder);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_div_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a divide; sampled on rising clk.
REQ-005 dividend  input  8  unsigned dividend, sampled with accepted start.
REQ-006 divisor  input  4  unsigned divisor, sampled with accepted start.
REQ-007 busy  output  1  high while an operation is iterating.
REQ-008 done  output  1  one-cycle pulse: results valid.
REQ-009 quotient  output  8  unsigned quotient, floor(dividend/divisor).
REQ-010 remainder  output  4  unsigned remainder, dividend mod divisor.
REQ-011 div_by_zero  output  1  present only with SEQ_DIVIDER_ZERO_DETECT_EN; high when the completed operation had divisor 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in RUN is ignored, with no effect on state or results.
REQ-014 On an accepted start at edge k: dividend and divisor are latched, the 5-bit partial remainder is cleared, the iteration counter is set to 7, and the FSM enters RUN.
REQ-015 Each RUN cycle SHALL do one restoring step, MSB first: shift the next dividend bit into the partial remainder; if it is >= divisor, subtract the divisor and set the quotient bit to 1, else set it to 0.
REQ-016 After 8 RUN cycles (edge k+8), the FSM SHALL enter DONE and register quotient and remainder; done=1 for the cycle between edges k+8 and k+9 (latency 8).
REQ-017 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-018 DONE SHALL return to IDLE after one cycle, unless start is high in DONE, in which case it goes straight to RUN (back-to-back; done still pulses that cycle).
REQ-019 quotient and remainder SHALL change only on entry to DONE, and SHALL hold their values through IDLE and through any following RUN.
REQ-020 Arithmetic: partial remainder 5 bits wide, and the final remainder is its low 4 bits; the result SHALL satisfy quotient*divisor+remainder == dividend and remainder < divisor for every divisor != 0.
REQ-021 divisor==0 SHALL produce quotient=8'hFF and remainder=4'h0.
REQ-022 A dividend or divisor change outside an accepted start SHALL NOT affect the operation in progress.

Reset
REQ-023 rst SHALL force state to IDLE immediately, independent of clk.
REQ-024 On reset, busy, done, quotient, remainder, div_by_zero and all internal registers SHALL be 0.
REQ-025 A reset in RUN SHALL abort the operation without a done pulse; the first start accepted after rst deasserts SHALL behave as in REQ-014.

Configuration
REQ-026 Macro SEQ_DIVIDER_ZERO_DETECT_EN SHALL control divide-by-zero early termination.
REQ-027 With the macro defined: div_by_zero exists; an accepted start with divisor==0 goes to DONE at edge k+1 (latency 1) with quotient=8'hFF, remainder=4'h0 and div_by_zero=1; div_by_zero holds until the next entry to DONE, clears on a non-zero-divisor completion, and busy stays 0 throughout.
REQ-028 Without the macro: div_by_zero is absent and divisor==0 runs the full 8-cycle latency with the REQ-021 result.

Verification
REQ-029 dividend=200, divisor=7, start at edge k -> busy high over edges k..k+8, done at k+8, quotient=28, remainder=4.
REQ-030 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 0/15 -> quotient=0, remainder=0.
REQ-031 start=1 pulsed mid-RUN with different operands -> ignored: the original result is produced at k+8 and there is exactly one done pulse.
REQ-032 start held high in DONE with 100/3 after a 200/7 result -> done pulses, 28/4 stays visible until 33/1 appears 8 cycles later.
REQ-033 rst asserted at edge k+4 of a run -> all outputs 0 immediately, no done; a following 9/2 start -> quotient=4, remainder=1.
REQ-034 divisor=0 -> with macro: done at k+1, div_by_zero=1, quotient=8'hFF, remainder=0; without macro: done at k+8 with the same values.
